// File: rtl/fp_add_normaliser_pipe.sv
// fp_add_normaliser_pipe: two-stage post-add normaliser (carry shift, leading-zero shift, zero/ovf/denormal)
module fp_add_normaliser_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_e,
  input  logic [MAN_W-1:0] in_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_m,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_udf
);
  localparam int LZ_W = $clog2(MAN_W);
  localparam logic [EXP_W-1:0] E_MAX = '1;
  logic             s1_valid_q, s1_valid_d, s1_c_q, s1_c_d;
  logic [EXP_W-1:0] s1_e_q, s1_e_d;
  logic [MAN_W-1:0] s1_m_q, s1_m_d;
  logic [LZ_W-1:0]  s1_lzc_q, s1_lzc_d, lzc;
  logic             out_valid_q, out_valid_d, out_zero_q, out_zero_d;
  logic             out_ovf_q, out_ovf_d, out_udf_q, out_udf_d;
  logic [EXP_W-1:0] out_e_q, out_e_d, e_sub, udf_sh;
  logic [MAN_W-1:0] out_m_q, out_m_d, sticky;
  logic [EXP_W:0]   e_x, e_inc, lz_x;
  logic             s1_en, s2_en, ovf;
  assign s2_en     = !out_valid_q || out_ready;
  assign s1_en     = !s1_valid_q || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = out_valid_q;
  assign out_e     = out_e_q;
  assign out_m     = out_m_q;
  assign out_zero  = out_zero_q;
  assign out_ovf   = out_ovf_q;
  assign out_udf   = out_udf_q;
  // Scan from LSB so the highest set bit of the fraction field wins.
  always_comb begin
    lzc = LZ_W'(MAN_W - 1);
    for (int i = 0; i < MAN_W - 1; i++)
      if (in_m[i]) lzc = LZ_W'(MAN_W - 2 - i);
  end
  always_comb begin
    s1_valid_d = s1_en ? in_valid : s1_valid_q;
    s1_e_d     = (s1_en && in_valid) ? in_e : s1_e_q;
    s1_m_d     = (s1_en && in_valid) ? in_m : s1_m_q;
    s1_c_d     = (s1_en && in_valid) ? in_m[MAN_W-1] : s1_c_q;
    s1_lzc_d   = (s1_en && in_valid) ? lzc : s1_lzc_q;
  end
  always_comb begin
    e_x    = {1'b0, s1_e_q};
    e_inc  = e_x + 1'b1;
    lz_x   = {{(EXP_W + 1 - LZ_W){1'b0}}, s1_lzc_q};
    e_sub  = s1_e_q - EXP_W'(s1_lzc_q);
    udf_sh = (s1_e_q == '0) ? '0 : s1_e_q - 1'b1;
    sticky = {1'b0, s1_m_q[MAN_W-1:1]} | MAN_W'(s1_m_q[0]);
    ovf    = e_inc >= {1'b0, E_MAX};
    out_valid_d = s2_en ? s1_valid_q : out_valid_q;
    out_e_d     = out_e_q;
    out_m_d     = out_m_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    out_udf_d   = out_udf_q;
    if (s2_en && s1_valid_q) begin
      out_zero_d = 1'b0;
      out_ovf_d  = 1'b0;
      out_udf_d  = 1'b0;
      if (s1_e_q == E_MAX) begin
        out_e_d = E_MAX;
        out_m_d = s1_c_q ? sticky : s1_m_q;
      end else if (s1_c_q) begin
        out_ovf_d = ovf;
        out_e_d   = ovf ? E_MAX : e_inc[EXP_W-1:0];
        out_m_d   = ovf ? '0 : sticky;
      end else if (s1_m_q == '0) begin
        out_zero_d = 1'b1;
        out_e_d    = '0;
        out_m_d    = '0;
      end else if (lz_x < e_x) begin
        out_e_d = e_sub;
        out_m_d = s1_m_q << s1_lzc_q;
      end else begin
        out_udf_d = 1'b1;
        out_e_d   = '0;
        out_m_d   = s1_m_q << udf_sh;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_c_q      <= 1'b0;
      s1_e_q      <= '0;
      s1_m_q      <= '0;
      s1_lzc_q    <= '0;
      out_valid_q <= 1'b0;
      out_e_q     <= '0;
      out_m_q     <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_udf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_c_q      <= s1_c_d;
      s1_e_q      <= s1_e_d;
      s1_m_q      <= s1_m_d;
      s1_lzc_q    <= s1_lzc_d;
      out_valid_q <= out_valid_d;
      out_e_q     <= out_e_d;
      out_m_q     <= out_m_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
      out_udf_q   <= out_udf_d;
    end
  end
endmodule
